// File: rtl/mul_fu_pipe.sv
// Pipelined sign-handling wrapper around an external unsigned multiplier array (RV64M MUL/MULH/MULHSU/MULHU/MULW).
// Define MUL_FU_OUT_REG_EN to add a third output register stage (latency 3 instead of 2).
module mul_fu_pipe #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic             in_word,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic [XLEN-1:0]  mul_a,
    output logic [XLEN-1:0]  mul_b,
    input  logic [XLEN-1:0]  mul_lo,
    input  logic [XLEN-1:0]  mul_hi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned PW = 2 * XLEN;
    localparam int unsigned WW = 32;

    logic             s1_valid_q, s1_valid_d;
    logic [XLEN-1:0]  s1_a_q, s1_a_d;
    logic [XLEN-1:0]  s1_b_q, s1_b_d;
    logic             s1_neg_q, s1_neg_d;
    logic             s1_hi_q, s1_hi_d;
    logic             s1_word_q, s1_word_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    logic             s2_valid_q, s2_valid_d;
    logic [XLEN-1:0]  s2_res_q, s2_res_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

    logic             adv2;
    logic             accept;
    logic             sign_a_used, sign_b_used;
    logic [PW-1:0]    prod, prod_fix;
    logic [XLEN-1:0]  res_sel;

`ifdef MUL_FU_OUT_REG_EN
    logic             s3_valid_q, s3_valid_d;
    logic [XLEN-1:0]  s3_res_q, s3_res_d;
    logic [TAG_W-1:0] s3_tag_q, s3_tag_d;
    logic             adv3;

    assign adv3       = !s3_valid_q || out_ready;
    assign adv2       = !s2_valid_q || adv3;
    assign out_valid  = s3_valid_q;
    assign out_result = s3_res_q;
    assign out_tag    = s3_tag_q;
`else
    assign adv2       = !s2_valid_q || out_ready;
    assign out_valid  = s2_valid_q;
    assign out_result = s2_res_q;
    assign out_tag    = s2_tag_q;
`endif

    assign in_ready = !s1_valid_q || adv2;
    assign accept   = in_valid && in_ready && !flush;
    assign mul_a    = s1_a_q;
    assign mul_b    = s1_b_q;

    // S1: operand decode into magnitudes; the result sign is restored in S2
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_neg_d    = s1_neg_q;
        s1_hi_d     = s1_hi_q;
        s1_word_d   = s1_word_q;
        s1_tag_d    = s1_tag_q;
        sign_a_used = ((in_op == 2'd1) || (in_op == 2'd2)) && in_rs1[XLEN-1];
        sign_b_used = (in_op == 2'd1) && in_rs2[XLEN-1];
        if (s1_valid_q && adv2) begin
            s1_valid_d = 1'b0;
        end
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_hi_d    = (in_op != 2'd0);
            s1_word_d  = in_word;
            s1_tag_d   = in_tag;
            if (in_word) begin
                s1_a_d   = {{(XLEN-WW){1'b0}}, in_rs1[WW-1:0]};
                s1_b_d   = {{(XLEN-WW){1'b0}}, in_rs2[WW-1:0]};
                s1_neg_d = 1'b0;
            end else begin
                s1_a_d   = sign_a_used ? (~in_rs1 + XLEN'(1)) : in_rs1;
                s1_b_d   = sign_b_used ? (~in_rs2 + XLEN'(1)) : in_rs2;
                s1_neg_d = sign_a_used ^ sign_b_used;
            end
        end
        if (flush) begin
            s1_valid_d = 1'b0;
        end
    end

    // S2: sign fix-up of the full product and half select
    always_comb begin
        prod     = {mul_hi, mul_lo};
        prod_fix = s1_neg_q ? (~prod + PW'(1)) : prod;
        if (s1_word_q) begin
            res_sel = {{(XLEN-WW){prod_fix[WW-1]}}, prod_fix[WW-1:0]};
        end else if (s1_hi_q) begin
            res_sel = prod_fix[PW-1:XLEN];
        end else begin
            res_sel = prod_fix[XLEN-1:0];
        end
        s2_valid_d = s2_valid_q;
        s2_res_d   = s2_res_q;
        s2_tag_d   = s2_tag_q;
        if (adv2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_res_d = res_sel;
                s2_tag_d = s1_tag_q;
            end
        end
        if (flush) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_neg_q   <= 1'b0;
            s1_hi_q    <= 1'b0;
            s1_word_q  <= 1'b0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
            s2_tag_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_neg_q   <= s1_neg_d;
            s1_hi_q    <= s1_hi_d;
            s1_word_q  <= s1_word_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_res_q   <= s2_res_d;
            s2_tag_q   <= s2_tag_d;
        end
    end

`ifdef MUL_FU_OUT_REG_EN
    // S3: optional output register, same advance rule as S2
    always_comb begin
        s3_valid_d = s3_valid_q;
        s3_res_d   = s3_res_q;
        s3_tag_d   = s3_tag_q;
        if (adv3) begin
            s3_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                s3_res_d = s2_res_q;
                s3_tag_d = s2_tag_q;
            end
        end
        if (flush) begin
            s3_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_valid_q <= 1'b0;
            s3_res_q   <= '0;
            s3_tag_q   <= '0;
        end else begin
            s3_valid_q <= s3_valid_d;
            s3_res_q   <= s3_res_d;
            s3_tag_q   <= s3_tag_d;
        end
    end
`endif

endmodule

// File: tb/tb_mul_fu_pipe.sv
// Directed self-checking bench for mul_fu_pipe with a behavioural multiplier array.
module tb_mul_fu_pipe;

`ifdef MUL_FU_OUT_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_op;
    logic         in_word;
    logic [63:0]  in_rs1, in_rs2;
    logic [5:0]   in_tag;
    logic [63:0]  mul_a, mul_b, mul_lo, mul_hi;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_result;
    logic [5:0]   out_tag;
    logic [127:0] prod;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign prod   = {64'd0, mul_a} * {64'd0, mul_b};
    assign mul_lo = prod[63:0];
    assign mul_hi = prod[127:64];

    mul_fu_pipe #(.XLEN(64), .TAG_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_word(in_word),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
        .mul_a(mul_a), .mul_b(mul_b), .mul_lo(mul_lo), .mul_hi(mul_hi),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag)
    );

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic word,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [5:0] tag, input logic [63:0] exp);
        int n = 0;
        in_valid = 1'b1; in_op = op; in_word = word;
        in_rs1 = a; in_rs2 = b; in_tag = tag; out_ready = 1'b1;
        while (!in_ready && n < 10) begin tick; n++; end
        tick;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin tick; n++; end
        check({name, "_lat"}, 64'(n), 64'(LAT));
        check(name, out_result, exp);
        check({name, "_tag"}, 64'(out_tag), 64'(tag));
        tick;
    endtask

    // mode 0: out_ready held high; mode 1: out_ready pattern 1,0,0 repeating
    task automatic stream(input int mode);
        logic [63:0] exp_q[$];
        logic [5:0]  tag_q[$];
        int sent = 0, got = 0, cyc = 0, first = -1, last = -1, inflight = 0;
        logic prev_stall = 1'b0;
        logic [63:0] prev_res = '0;
        logic [5:0]  prev_tag = '0;
        logic acc, del;
        while ((sent < 8 || got < 8) && cyc < 200) begin
            out_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
            if (sent < 8) begin
                in_valid = 1'b1;
                in_word  = 1'b0;
                in_tag   = 6'(sent + 8);
                if (sent % 2 == 0) begin
                    in_op = 2'd0; in_rs1 = 64'(sent + 1); in_rs2 = 64'd10;
                end else begin
                    in_op = 2'd3; in_rs1 = '1; in_rs2 = 64'(sent + 1);
                end
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (prev_stall) begin
                check("stall_res", out_result, prev_res);
                check("stall_tag", 64'(out_tag), 64'(prev_tag));
            end
            check("stream_in_ready", 64'(in_ready), 64'(!(inflight == LAT && !out_ready)));
            acc = in_valid && in_ready;
            del = out_valid && out_ready;
            if (del) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 64'(out_valid), 64'd0);
                end else begin
                    check("stream_res", out_result, exp_q.pop_front());
                    check("stream_tag", 64'(out_tag), 64'(tag_q.pop_front()));
                    got++;
                    if (first < 0) first = cyc;
                    last = cyc;
                end
            end
            if (acc) begin
                exp_q.push_back((sent % 2 == 0) ? 64'(10 * (sent + 1)) : 64'(sent));
                tag_q.push_back(6'(sent + 8));
                sent++;
            end
            inflight += int'(acc) - int'(del);
            prev_stall = out_valid && !out_ready;
            prev_res   = out_result;
            prev_tag   = out_tag;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("stream_sent", 64'(sent), 64'd8);
        check("stream_got", 64'(got), 64'd8);
        if (mode == 0) check("stream_no_bubble", 64'(last - first), 64'd7);
        tick;
        check("stream_drained", 64'(out_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        int n;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = 2'd0; in_word = 1'b0;
        in_rs1 = '0; in_rs2 = '0; in_tag = '0; out_ready = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_result", out_result, 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_mul_a", mul_a, 64'd0);
        tick; tick;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin tick; seen |= out_valid; end
        check("idle_no_out", 64'(seen), 64'd0);

        run_op("mulh_min",    2'd1, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 6'd1, 64'h4000_0000_0000_0000);
        run_op("mulhu_min",   2'd3, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 6'd2, 64'h4000_0000_0000_0000);
        run_op("mulhsu_min",  2'd2, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 6'd3, 64'hC000_0000_0000_0000);
        run_op("mul_m1x5",    2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 6'd4, 64'hFFFF_FFFF_FFFF_FFFB);
        run_op("mulh_m1x5",   2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 6'd5, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("mulhu_m1x5",  2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 6'd6, 64'h0000_0000_0000_0004);
        run_op("mulhsu_m1x5", 2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 6'd7, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("mulh_3xm2",   2'd1, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 6'd8, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("mul_3xm2",    2'd0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 6'd9, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op("mulw",        2'd0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 6'd10, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("mulw_garbage",2'd0, 1'b1, 64'hDEAD_BEEF_7FFF_FFFF, 64'h1234_5678_0000_0002, 6'd11, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("mulw_pos",    2'd0, 1'b1, 64'h0000_0000_0000_1000, 64'h0000_0000_0000_0300, 6'd12, 64'h0000_0000_0030_0000);

        stream(0);
        stream(1);

        // flush with every stage full and another op presented
        out_ready = 1'b0; in_valid = 1'b1; in_op = 2'd0; in_word = 1'b0;
        in_rs1 = 64'd7; in_rs2 = 64'd9; in_tag = 6'd50;
        n = 0;
        while (in_ready && n < 6) begin tick; n++; in_tag = in_tag + 6'd1; end
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_out_valid", 64'(out_valid), 64'd1);
        flush = 1'b1;
        tick;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin tick; seen |= out_valid; end
        check("flush_no_out", 64'(seen), 64'd0);

        // reset asserted with ops in flight
        in_valid = 1'b1; in_op = 2'd3; in_rs1 = 64'd11; in_rs2 = 64'd13; in_tag = 6'd60;
        tick;
        in_tag = 6'd61;
        tick;
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_mul_a", mul_a, 64'd0);
        tick;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin tick; seen |= out_valid; end
        check("midrst_no_out", 64'(seen), 64'd0);

        run_op("post_rst_mul", 2'd0, 1'b0, 64'd6, 64'd7, 6'd33, 64'd42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
